// File: rtl/display_arbiter_pkg.sv
// Shared types and constants for the 4-digit seven-segment display path.
// Used by the display arbiter, its bus interface and the testbench.
package display_pkg;

    localparam int DIGITS  = 4;
    localparam int NIB_W   = 4;
    localparam int VALUE_W = DIGITS * NIB_W;

    // Display ownership state: B is the resting owner, A is granted then held.
    typedef enum logic [1:0] {
        SHOW_B  = 2'd0,
        GRANT_A = 2'd1,
        HOLD_A  = 2'd2
    } state_t;

    // Four nibbles, digit3 in the top nibble.
    typedef logic [VALUE_W-1:0] disp_value_t;

    // Per-digit blank mask, bit n = digit n dark.
    typedef logic [DIGITS-1:0] blank_mask_t;

endpackage

// File: rtl/display_arbiter_if.sv
// Bus between the two value sources, the arbiter and the digit scanner.
// master: the side driving requests and source values.
// slave:  the arbiter itself.
interface display_arbiter_if;
    import display_pkg::*;

    logic        a_req;
    disp_value_t a_value;
    logic        a_ack;
    disp_value_t b_value;
    disp_value_t disp_value;
    blank_mask_t disp_blank;
    logic        scan_tick;
    logic        owner;

    modport master (
        output a_req,
        output a_value,
        output b_value,
        input  a_ack,
        input  disp_value,
        input  disp_blank,
        input  scan_tick,
        input  owner
    );

    modport slave (
        input  a_req,
        input  a_value,
        input  b_value,
        output a_ack,
        output disp_value,
        output disp_blank,
        output scan_tick,
        output owner
    );

endinterface

// File: rtl/display_arbiter_tick_prescaler.sv
// Free-running clock divider producing a one-cycle scan tick every CLK_DIV
// cycles. Shared by the scanned display blocks.
module tick_prescaler #(
    parameter int CLK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic scan_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_p1;

    // Count 0..CLK_DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1 <= '0;
        end else if (cnt_p1 == CNT_LAST) begin
            cnt_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign scan_tick = (cnt_p1 == CNT_LAST);

endmodule

// File: rtl/display_arbiter.sv
// Display arbiter: shares the 4-digit scan path between source B (default,
// running count) and source A (alert value, granted and held for HOLD_TICKS
// scan ticks). B is guaranteed MIN_B_TICKS scan ticks between two A grants.
// Optional build macro DISPLAY_ARBITER_LZ_BLANK_EN enables leading-zero
// blanking; without it disp_blank stays all zero.
module display_arbiter
    import display_pkg::*;
#(
    parameter int CLK_DIV     = 100000,
    parameter int HOLD_TICKS  = 2000,
    parameter int MIN_B_TICKS = 500
) (
    input  logic              clk,
    input  logic              reset,
    display_arbiter_if.slave  bus
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int MINB_W = (MIN_B_TICKS > 0) ? $clog2(MIN_B_TICKS + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [MINB_W-1:0] MIN_B_MAX = MINB_W'(MIN_B_TICKS);

    logic scan_tick;

    state_t            state_p1,     state_p0;
    disp_value_t       disp_p1,      disp_p0;
    blank_mask_t       blank_p1,     blank_p0;
    logic              owner_p1,     owner_p0;
    logic [HOLD_W-1:0] hold_cnt_p1,  hold_cnt_p0;
    logic [MINB_W-1:0] min_b_cnt_p1, min_b_cnt_p0;

`ifdef DISPLAY_ARBITER_LZ_BLANK_EN
    // Blank leading zero digits; digit 0 always lit so a zero value shows "0".
    function automatic blank_mask_t lz_blank(input disp_value_t v);
        blank_mask_t m;
        m = '0;
        m[DIGITS-1] = (v[VALUE_W-1 -: NIB_W] == '0);
        for (int d = DIGITS - 2; d >= 1; d--) begin
            m[d] = m[d+1] & (v[d*NIB_W +: NIB_W] == '0);
        end
        m[0] = 1'b0;
        return m;
    endfunction
`endif

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .scan_tick (scan_tick)
    );

    // Next-state, next display value and counter updates for the ownership FSM.
    always_comb begin
        state_p0     = state_p1;
        disp_p0      = disp_p1;
        owner_p0     = owner_p1;
        hold_cnt_p0  = hold_cnt_p1;
        min_b_cnt_p0 = min_b_cnt_p1;
        bus.a_ack    = 1'b0;

        unique case (state_p1)
            SHOW_B: begin
                disp_p0  = bus.b_value;
                owner_p0 = 1'b0;
                if (scan_tick && (min_b_cnt_p1 != MIN_B_MAX)) begin
                    min_b_cnt_p0 = min_b_cnt_p1 + 1'b1;
                end
                if (bus.a_req && (min_b_cnt_p1 == MIN_B_MAX)) begin
                    state_p0 = GRANT_A;
                end
            end
            GRANT_A: begin
                // A tick landing here is deliberately not counted toward the hold.
                bus.a_ack   = 1'b1;
                disp_p0     = bus.a_value;
                owner_p0    = 1'b1;
                hold_cnt_p0 = '0;
                state_p0    = HOLD_A;
            end
            HOLD_A: begin
                if (scan_tick) begin
                    if (hold_cnt_p1 == HOLD_LAST) begin
                        state_p0     = SHOW_B;
                        owner_p0     = 1'b0;
                        min_b_cnt_p0 = '0;
                        disp_p0      = bus.b_value;
                    end else begin
                        hold_cnt_p0 = hold_cnt_p1 + 1'b1;
                    end
                end
            end
            default: begin
                state_p0 = SHOW_B;
            end
        endcase
    end

    // Blank mask follows the next display value so both register together.
    always_comb begin
`ifdef DISPLAY_ARBITER_LZ_BLANK_EN
        blank_p0 = lz_blank(disp_p0);
`else
        blank_p0 = '0;
`endif
    end

    // State, counters and display registers; reset makes A grantable at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1     <= SHOW_B;
            disp_p1      <= '0;
            blank_p1     <= '0;
            owner_p1     <= 1'b0;
            hold_cnt_p1  <= '0;
            min_b_cnt_p1 <= MIN_B_MAX;
        end else begin
            state_p1     <= state_p0;
            disp_p1      <= disp_p0;
            blank_p1     <= blank_p0;
            owner_p1     <= owner_p0;
            hold_cnt_p1  <= hold_cnt_p0;
            min_b_cnt_p1 <= min_b_cnt_p0;
        end
    end

    assign bus.disp_value = disp_p1;
    assign bus.disp_blank = blank_p1;
    assign bus.owner      = owner_p1;
    assign bus.scan_tick  = scan_tick;

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// countdown-based reference model of the display ownership rules.
module tb_display_arbiter;
    import display_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int HOLD_TICKS  = 3;
    localparam int MIN_B_TICKS = 2;

`ifdef DISPLAY_ARBITER_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    display_arbiter_if bus ();

    display_arbiter #(
        .CLK_DIV     (CLK_DIV),
        .HOLD_TICKS  (HOLD_TICKS),
        .MIN_B_TICKS (MIN_B_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected blank: top N digits dark where N = number of leading zero
    // nibbles, never more than three.
    function automatic logic [3:0] exp_blank(input logic [15:0] v);
        int lead;
        logic [3:0] ones;
        lead = 0;
        ones = 4'hF;
        for (int d = 3; d >= 1; d--) begin
            if ((v[d*4 +: 4] == 4'h0) && (lead == 3 - d)) lead++;
        end
        return LZ_EN ? (ones << (4 - lead)) : 4'b0000;
    endfunction

    // ---------------- reference model ----------------
    bit          m_valid = 1'b0;
    int          m_pre;          // prescaler phase of the current cycle
    int          m_hold_left;    // scan ticks A still owns the display
    int          m_b_ticks;      // scan ticks of B shown since A released
    logic [15:0] e_disp;
    bit          e_owner;
    bit          e_ack;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid     = 1'b1;
                m_pre       = 0;
                m_hold_left = 0;
                m_b_ticks   = MIN_B_TICKS;
                e_disp      = 16'h0000;
                e_owner     = 1'b0;
                e_ack       = 1'b0;
            end else if (m_valid) begin
                bit tick_prev;
                tick_prev = (m_pre == CLK_DIV - 1);
                m_pre = (m_pre + 1) % CLK_DIV;
                if (e_ack) begin
                    e_ack       = 1'b0;
                    e_disp      = bus.a_value;
                    e_owner     = 1'b1;
                    m_hold_left = HOLD_TICKS;
                end else if (e_owner) begin
                    if (tick_prev) begin
                        m_hold_left--;
                        if (m_hold_left == 0) begin
                            e_owner   = 1'b0;
                            e_disp    = bus.b_value;
                            m_b_ticks = 0;
                        end
                    end
                end else begin
                    e_disp = bus.b_value;
                    if (bus.a_req && (m_b_ticks >= MIN_B_TICKS)) e_ack = 1'b1;
                    if (tick_prev) m_b_ticks++;
                end
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("disp_value", bus.disp_value, e_disp);
                check("owner",      bus.owner,      e_owner);
                check("a_ack",      bus.a_ack,      e_ack);
                check("scan_tick",  bus.scan_tick,  (m_pre == CLK_DIV - 1));
                check("disp_blank", bus.disp_blank, exp_blank(e_disp));
            end
        end
    end

    // ---------------- stimulus ----------------
    int ticks;
    int guard;

    task automatic wait_owner_low(input string name);
        int g;
        g = 0;
        while (bus.owner !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check({name, "_timeout"}, bus.owner, 0);
    endtask

    initial begin
        bus.a_req   = 1'b0;
        bus.a_value = 16'h0000;
        bus.b_value = 16'h1234;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: B shown after reset, scan tick every 4th cycle
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("rst_disp_b",  bus.disp_value, 16'h1234);
                check("rst_owner",   bus.owner, 0);
                check("rst_no_ack",  bus.a_ack, 0);
            end
            check("tick_cadence", bus.scan_tick, (i % 4 == 3) ? 1 : 0);
        end

        // 2: A request at idle, grant and hold for three ticks
        bus.a_req   = 1'b1;
        bus.a_value = 16'hBEEF;
        @(negedge clk);
        check("grant_ack",  bus.a_ack, 1);
        check("grant_disp", bus.disp_value, 16'h1234);
        bus.a_req = 1'b0;
        @(negedge clk);
        check("ack_width",  bus.a_ack, 0);
        check("a_shown",    bus.disp_value, 16'hBEEF);
        check("a_owner",    bus.owner, 1);

        // 4: during hold, A inputs are ignored
        ticks = 0;
        guard = 0;
        while (bus.owner === 1'b1 && guard < 60) begin
            if (bus.scan_tick) ticks++;
            check("hold_frozen", bus.disp_value, 16'hBEEF);
            check("hold_no_ack", bus.a_ack, 0);
            bus.a_req   = ~bus.a_req;
            bus.a_value = 16'h0000;
            @(negedge clk);
            guard++;
        end
        check("hold_ticks", ticks, HOLD_TICKS);
        check("b_after_hold", bus.disp_value, 16'h1234);

        // 3: request held high, grants separated by MIN_B_TICKS of B
        bus.a_req   = 1'b1;
        bus.a_value = 16'hBEEF;
        for (int r = 0; r < 2; r++) begin
            ticks = 0;
            guard = 0;
            while (bus.a_ack !== 1'b1 && guard < 100) begin
                if (bus.scan_tick) ticks++;
                @(negedge clk);
                guard++;
            end
            check("b_gap_ticks", ticks, MIN_B_TICKS);
            @(negedge clk);
            check("regrant_ack_width", bus.a_ack, 0);
            if (r == 0) wait_owner_low("regrant_release");
        end

        // 5: reset in the middle of a hold
        repeat (3) @(negedge clk);
        check("pre_reset_owner", bus.owner, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_owner", bus.owner, 0);
        check("midrst_disp",  bus.disp_value, 16'h0000);
        check("midrst_ack",   bus.a_ack, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_grant", bus.a_ack, 1);
        bus.a_req = 1'b0;
        @(negedge clk);
        wait_owner_low("post_rst_release");

        // 6: blank masks for a few B values
        bus.b_value = 16'h0042;
        repeat (2) @(negedge clk);
        check("blank_0042", bus.disp_blank, LZ_EN ? 4'b1100 : 4'b0000);
        bus.b_value = 16'h0000;
        repeat (2) @(negedge clk);
        check("blank_0000", bus.disp_blank, LZ_EN ? 4'b1110 : 4'b0000);
        bus.b_value = 16'h1000;
        repeat (2) @(negedge clk);
        check("blank_1000", bus.disp_blank, 4'b0000);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.a_req = ~bus.a_req;
            bus.a_value = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bus.b_value = 16'h0000;
                    1:       bus.b_value = 16'($urandom_range(0, 255));
                    default: bus.b_value = 16'($urandom);
                endcase
            end
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
